// File: rtl/sdram_burst_reader.sv
// Single-bank-burst SDRAM read controller: ACTIVE, READ with auto-precharge,
// capture of BURST_LEN words after CAS latency, then precharge wait and a done pulse.
`timescale 1ns/1ps

module sdram_burst_reader #(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int BANK_W    = 2,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 2,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              ienb,
    input  logic              ireq,
    input  logic [ROW_W-1:0]  irow,
    input  logic [COL_W-1:0]  icolumn,
    input  logic [BANK_W-1:0] ibank,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic              obusy,
    output logic              ofin,
    output logic              DRAM_CLK,
    output logic              DRAM_CKE,
    output logic              DRAM_CS_N,
    output logic              DRAM_RAS_N,
    output logic              DRAM_CAS_N,
    output logic              DRAM_WE_N,
    output logic              DRAM_LDQM,
    output logic              DRAM_UDQM,
    output logic [ROW_W-1:0]  DRAM_ADDR,
    output logic [BANK_W-1:0] DRAM_BA,
    inout  wire  [DATA_W-1:0] DRAM_DQ
);

    localparam int WAIT_MAX_A = (T_RCD > CAS_LAT) ? T_RCD : CAS_LAT;
    localparam int WAIT_MAX   = (WAIT_MAX_A > T_RP) ? WAIT_MAX_A : T_RP;
    localparam int WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam int CNT_W      = $clog2(BURST_LEN) + 1;
    localparam int AP_BIT     = 10;

    typedef enum logic [2:0] {
        IDLE,
        ACT,
        RCD,
        RD,
        CAS,
        DATA,
        RP,
        FIN
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ROW_W-1:0]    row_reg, row_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [BANK_W-1:0]   bank_reg, bank_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                valid_reg, valid_next;
    logic                cke_reg;
    logic                ras_n_reg, ras_n_next;
    logic                cas_n_reg, cas_n_next;
    logic [ROW_W-1:0]    addr_reg, addr_next;
    logic [BANK_W-1:0]   ba_reg, ba_next;
    logic [ROW_W-1:0]    read_addr;
    logic                capture;

    // READ address: column in the low bits, A10 set for auto-precharge, rest zero.
    genvar gi;
    generate
        for (gi = 0; gi < ROW_W; gi++) begin : g_rd_addr
            if (gi == AP_BIT) begin : g_ap
                assign read_addr[gi] = 1'b1;
            end else if (gi < COL_W) begin : g_col
                assign read_addr[gi] = col_reg[gi];
            end else begin : g_zero
                assign read_addr[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        bank_next  = bank_reg;
        capture    = 1'b0;
        ras_n_next = 1'b1;
        cas_n_next = 1'b1;
        addr_next  = '0;
        ba_next    = '0;

        case (state_reg)
            IDLE: begin
                // CKE low means this is the first edge after reset release.
                if (ireq && ienb && cke_reg) begin
                    state_next = ACT;
                    row_next   = irow;
                    col_next   = icolumn;
                    bank_next  = ibank;
                end
            end
            ACT: begin
                state_next = (T_RCD == 1) ? RD : RCD;
            end
            RCD: begin
                if (int'(wait_reg) >= T_RCD - 2) begin
                    state_next = RD;
                end
            end
            RD: begin
                state_next = CAS;
            end
            CAS: begin
                if (int'(wait_reg) >= CAS_LAT - 1) begin
                    capture    = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_W'(BURST_LEN)) begin
                    state_next = RP;
                end else begin
                    capture = 1'b1;
                end
            end
            RP: begin
                if (int'(wait_reg) >= T_RP - 1) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Commands are registered one cycle ahead so they appear with the new state.
        if (state_next == ACT) begin
            ras_n_next = 1'b0;
            addr_next  = row_next;
            ba_next    = bank_next;
        end else if (state_next == RD) begin
            cas_n_next = 1'b0;
            addr_next  = read_addr;
            ba_next    = bank_reg;
        end
    end

    always_comb begin
        wait_next = '0;
        if ((state_reg == RCD || state_reg == CAS || state_reg == RP) &&
            (state_next == state_reg)) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (state_next == ACT) begin
            cnt_next = '0;
        end else if (capture) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_comb begin
        data_next  = data_reg;
        valid_next = capture;
        if (capture) begin
            data_next = DRAM_DQ;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_reg <= IDLE;
            wait_reg  <= '0;
            cnt_reg   <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            bank_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            cke_reg   <= 1'b0;
            ras_n_reg <= 1'b1;
            cas_n_reg <= 1'b1;
            addr_reg  <= '0;
            ba_reg    <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            cnt_reg   <= cnt_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            bank_reg  <= bank_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            cke_reg   <= 1'b1;
            ras_n_reg <= ras_n_next;
            cas_n_reg <= cas_n_next;
            addr_reg  <= addr_next;
            ba_reg    <= ba_next;
        end
    end

    assign odata      = data_reg;
    assign ovalid     = valid_reg;
    assign obusy      = (state_reg != IDLE);
    assign ofin       = (state_reg == FIN);

    assign DRAM_CLK   = ~iclk;
    assign DRAM_CKE   = cke_reg;
    assign DRAM_CS_N  = 1'b0;
    assign DRAM_RAS_N = ras_n_reg;
    assign DRAM_CAS_N = cas_n_reg;
    assign DRAM_WE_N  = 1'b1;
    assign DRAM_LDQM  = 1'b0;
    assign DRAM_UDQM  = 1'b0;
    assign DRAM_ADDR  = addr_reg;
    assign DRAM_BA    = ba_reg;
    assign DRAM_DQ    = {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Randomised bench for sdram_burst_reader: three instances (BL4/CL2, BL8/CL3, BL1/CL3)
// share the request inputs; a timing model predicts commands, words and done pulses.
`timescale 1ns/1ps

module tb_sdram_burst_reader;

    localparam int T_RCD = 2;
    localparam int T_RP  = 2;

    typedef struct {
        int         cyc;
        logic       is_read;
        logic [12:0] addr;
        logic [1:0] ba;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enb = 1'b0;
    logic        req = 1'b0;
    logic [12:0] row = '0;
    logic [9:0]  col = '0;
    logic [1:0]  bank = '0;
    logic        drain_done = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    initial forever #5 clk = ~clk;

    // cyc = index of the cycle that ends at the next rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=0x%0h expected=0x%0h", name, inst, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [1:0] b, input logic [12:0] r,
                                             input logic [9:0] c, input int k);
        logic [31:0] h;
        h = {7'd0, b, r, c} * 32'h0000_9E37 + k * 32'h0000_1111 + 32'h5A5A;
        return h[15:0] ^ h[31:16];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_inst
            localparam int BL  = (gi == 1) ? 8 : ((gi == 2) ? 1 : 4);
            localparam int CL  = (gi == 0) ? 2 : 3;
            localparam int LAT = 1 + T_RCD + CL + BL + T_RP;

            wire  [15:0] dq;
            logic [15:0] dq_drv = '0;
            logic        dq_en = 1'b0;
            assign dq = dq_en ? dq_drv : 16'hzzzz;

            logic [15:0] odata;
            logic        ovalid, obusy, ofin;
            logic        d_clk, cke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
            logic [12:0] addr;
            logic [1:0]  ba;

            sdram_burst_reader #(
                .ROW_W(13), .COL_W(10), .BANK_W(2), .DATA_W(16),
                .BURST_LEN(BL), .CAS_LAT(CL), .T_RCD(T_RCD), .T_RP(T_RP)
            ) u_dut (
                .iclk(clk), .ireset_n(rst_n), .ienb(enb), .ireq(req),
                .irow(row), .icolumn(col), .ibank(bank),
                .odata(odata), .ovalid(ovalid), .obusy(obusy), .ofin(ofin),
                .DRAM_CLK(d_clk), .DRAM_CKE(cke), .DRAM_CS_N(cs_n),
                .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n),
                .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm),
                .DRAM_ADDR(addr), .DRAM_BA(ba), .DRAM_DQ(dq)
            );

            cmd_t  cmd_q[$];
            word_t word_q[$];
            word_t dq_q[$];
            int    fin_q[$];
            int    next_ok = 0;
            int    busy_lo = 0;
            int    busy_hi = -1;
            bit    cke_m = 1'b0;
            bit    armed = 1'b0;
            logic [12:0] act_row [4];

            // Reference: an accepted request at edge e fixes the whole burst schedule.
            initial forever begin
                @(posedge clk);
                if (!rst_n) begin
                    cke_m = 1'b0;
                end else begin
                    if (cke_m && req && enb && cyc >= next_ok) begin
                        cmd_t c;
                        word_t w;
                        c.cyc = cyc + 1; c.is_read = 1'b0; c.addr = row; c.ba = bank;
                        cmd_q.push_back(c);
                        c.cyc = cyc + 1 + T_RCD; c.is_read = 1'b1;
                        c.addr = {3'b001, col}; c.ba = bank;
                        cmd_q.push_back(c);
                        for (int k = 0; k < BL; k++) begin
                            w.cyc = cyc + 2 + T_RCD + CL + k;
                            w.data = mem_word(bank, row, col, k);
                            word_q.push_back(w);
                        end
                        fin_q.push_back(cyc + LAT + 1);
                        busy_lo = cyc + 1;
                        busy_hi = cyc + LAT + 1;
                        next_ok = cyc + LAT + 2;
                    end
                    cke_m = 1'b1;
                end
            end

            // Reset abandons everything in flight; outputs must already be at reset values.
            initial forever begin
                @(negedge rst_n);
                cmd_q.delete();
                word_q.delete();
                dq_q.delete();
                fin_q.delete();
                dq_en = 1'b0;
                busy_hi = -1;
                next_ok = 0;
                cke_m = 1'b0;
                armed = 1'b1;
                #1;
                chk("rst_obusy", gi, {31'd0, obusy}, 32'd0);
                chk("rst_ovalid", gi, {31'd0, ovalid}, 32'd0);
                chk("rst_ofin", gi, {31'd0, ofin}, 32'd0);
                chk("rst_odata", gi, {16'd0, odata}, 32'd0);
                chk("rst_addr", gi, {19'd0, addr}, 32'd0);
                chk("rst_ba", gi, {30'd0, ba}, 32'd0);
                chk("rst_cke", gi, {31'd0, cke}, 32'd0);
                chk("rst_cmd", gi, {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h7);
            end

            // Monitor plus SDRAM data model, sampled mid-cycle.
            initial forever begin
                @(negedge clk);
                if (armed) begin
                    logic is_act, is_read;
                    dq_en = 1'b0;
                    while (dq_q.size() > 0 && dq_q[0].cyc < cyc) void'(dq_q.pop_front());
                    if (dq_q.size() > 0 && dq_q[0].cyc == cyc) begin
                        dq_drv = dq_q[0].data;
                        dq_en = 1'b1;
                        void'(dq_q.pop_front());
                    end

                    is_act  = !ras_n && cas_n && we_n;
                    is_read = ras_n && !cas_n && we_n;
                    while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                        chk("cmd_missing_cycle", gi, 32'(cyc), 32'(cmd_q[0].cyc));
                        void'(cmd_q.pop_front());
                    end
                    if (!(ras_n && cas_n && we_n)) begin
                        if (cmd_q.size() == 0 || cmd_q[0].cyc != cyc) begin
                            chk("cmd_unexpected", gi, {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h7);
                        end else begin
                            chk("cmd_kind", gi, {30'd0, is_act, is_read}, {30'd0, !cmd_q[0].is_read, cmd_q[0].is_read});
                            chk("cmd_addr", gi, {19'd0, addr}, {19'd0, cmd_q[0].addr});
                            chk("cmd_ba", gi, {30'd0, ba}, {30'd0, cmd_q[0].ba});
                            void'(cmd_q.pop_front());
                        end
                        if (is_act) act_row[ba] = addr;
                        if (is_read) begin
                            for (int k = 0; k < BL; k++) begin
                                word_t w;
                                w.cyc = cyc + CL + k;
                                w.data = mem_word(ba, act_row[ba], addr[9:0], k);
                                dq_q.push_back(w);
                            end
                        end
                    end

                    while (word_q.size() > 0 && word_q[0].cyc < cyc) begin
                        chk("valid_missing_cycle", gi, 32'(cyc), 32'(word_q[0].cyc));
                        void'(word_q.pop_front());
                    end
                    if (ovalid) begin
                        if (word_q.size() == 0 || word_q[0].cyc != cyc) begin
                            chk("valid_unexpected", gi, {31'd0, ovalid}, 32'd0);
                        end else begin
                            chk("odata", gi, {16'd0, odata}, {16'd0, word_q[0].data});
                            void'(word_q.pop_front());
                        end
                    end

                    while (fin_q.size() > 0 && fin_q[0] < cyc) begin
                        chk("fin_missing_cycle", gi, 32'(cyc), 32'(fin_q[0]));
                        void'(fin_q.pop_front());
                    end
                    if (ofin) begin
                        if (fin_q.size() == 0 || fin_q[0] != cyc) begin
                            chk("fin_unexpected", gi, {31'd0, ofin}, 32'd0);
                        end else begin
                            chk("fin_cycle", gi, 32'(cyc), 32'(fin_q[0]));
                            void'(fin_q.pop_front());
                        end
                    end

                    chk("obusy", gi, {31'd0, obusy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
                    chk("cke", gi, {31'd0, cke}, {31'd0, cke_m});
                    chk("cs_n_dqm", gi, {30'd0, cs_n, ldqm | udqm}, 32'd0);
                    chk("dram_clk", gi, {31'd0, d_clk}, {31'd0, ~clk});
                end
            end

            initial begin
                wait (drain_done);
                chk("left_cmds", gi, 32'(cmd_q.size()), 32'd0);
                chk("left_words", gi, 32'(word_q.size()), 32'd0);
                chk("left_fins", gi, 32'(fin_q.size()), 32'd0);
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_addr();
        row  = 13'($urandom);
        col  = 10'($urandom);
        bank = 2'($urandom);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #22 rst_n = 1'b1;
        tick();

        // Directed burst from the worked example.
        row = 13'h0A5; col = 10'h012; bank = 2'd2; req = 1'b1; enb = 1'b1;
        tick();
        req = 1'b0;
        repeat (25) tick();

        // Request held high: back-to-back bursts.
        req = 1'b1; enb = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rand_addr();
            tick();
        end
        req = 1'b0;
        repeat (20) tick();

        // Request with enable low: nothing may start.
        req = 1'b1; enb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rand_addr();
            tick();
        end

        // Random request/enable traffic, enable toggling mid-burst.
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) != 0);
            enb = 1'($urandom_range(0, 1));
            rand_addr();
            tick();
        end
        req = 1'b0;
        repeat (25) tick();

        // Reset during the second data word of the default instance.
        rand_addr(); req = 1'b1; enb = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #2 req = 1'b1; enb = 1'b1;
        rand_addr();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 req = 1'b0;
        repeat (25) tick();

        for (int i = 0; i < 200; i++) begin
            req = ($urandom_range(0, 2) != 0);
            enb = ($urandom_range(0, 4) != 0);
            rand_addr();
            tick();
        end
        req = 1'b0;
        repeat (30) tick();

        drain_done = 1'b1;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
